// File: rtl/id_stage_if.sv
// Handshake bundles on both sides of the decode stage.
// if_id_if carries the fetch bus; id_ex_if carries the ID/EX pipeline register and the downstream flush.
interface if_id_if;
  localparam int unsigned INSTR_WIDTH = 32;

  logic                   if_valid;
  logic                   if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;

  modport master (
    output if_valid,
    output if_instr,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    output if_ready
  );
endinterface

interface id_ex_if #(
  parameter int unsigned RF_ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH       = 16
);
  localparam int unsigned ALU_OP_WIDTH = 3;
  localparam int unsigned TARGET_WIDTH = 26;

  logic                        ex_valid;
  logic                        ex_ready;
  logic                        flush;
  logic [ALU_OP_WIDTH-1:0]     ex_alu_op;
  logic                        ex_alu_src_imm;
  logic                        ex_reg_write;
  logic                        ex_mem_read;
  logic                        ex_mem_write;
  logic                        ex_branch;
  logic                        ex_jump;
  logic                        ex_illegal;
  logic [RF_ADDRESS_WIDTH-1:0] ex_dest;
  logic [RF_ADDRESS_WIDTH-1:0] ex_rs1;
  logic [RF_ADDRESS_WIDTH-1:0] ex_rs2;
  logic [DATA_WIDTH-1:0]       ex_imm;
  logic [TARGET_WIDTH-1:0]     ex_target;

  modport master (
    output ex_valid,
    output ex_alu_op,
    output ex_alu_src_imm,
    output ex_reg_write,
    output ex_mem_read,
    output ex_mem_write,
    output ex_branch,
    output ex_jump,
    output ex_illegal,
    output ex_dest,
    output ex_rs1,
    output ex_rs2,
    output ex_imm,
    output ex_target,
    input  ex_ready,
    input  flush
  );

  modport slave (
    input  ex_valid,
    input  ex_alu_op,
    input  ex_alu_src_imm,
    input  ex_reg_write,
    input  ex_mem_read,
    input  ex_mem_write,
    input  ex_branch,
    input  ex_jump,
    input  ex_illegal,
    input  ex_dest,
    input  ex_rs1,
    input  ex_rs2,
    input  ex_imm,
    input  ex_target,
    output ex_ready,
    output flush
  );
endinterface

// File: rtl/id_stage.sv
// MIPS-subset instruction decode stage: register-file addressing, control decode into the
// ID/EX register, load-use bubble insertion, flush handling and a saturating stall counter.
module id_stage #(
  parameter int unsigned RF_ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  if_id_if.slave                      if_bus,
  id_ex_if.master                     ex_bus,
  output logic [RF_ADDRESS_WIDTH-1:0] rs1,
  output logic [RF_ADDRESS_WIDTH-1:0] rs2,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);

  localparam int unsigned OP_WIDTH     = 6;
  localparam int unsigned ALU_OP_WIDTH = 3;
  localparam int unsigned TARGET_WIDTH = 26;
  localparam int unsigned IMM_WIDTH    = 16;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;

  localparam logic [OP_WIDTH-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_WIDTH-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_WIDTH-1:0] FN_AND = 6'b100100;
  localparam logic [OP_WIDTH-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_WIDTH-1:0] FN_SLT = 6'b101010;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e                     alu_op;
    logic                        alu_src_imm;
    logic                        reg_write;
    logic                        mem_read;
    logic                        mem_write;
    logic                        branch;
    logic                        jump;
    logic                        illegal;
    logic [RF_ADDRESS_WIDTH-1:0] dest;
    logic [RF_ADDRESS_WIDTH-1:0] rs1;
    logic [RF_ADDRESS_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0]       imm;
    logic [TARGET_WIDTH-1:0]     target;
  } id_ex_t;

  logic [OP_WIDTH-1:0]         op;
  logic [OP_WIDTH-1:0]         funct;
  logic [RF_ADDRESS_WIDTH-1:0] fld_rs;
  logic [RF_ADDRESS_WIDTH-1:0] fld_rt;
  logic [RF_ADDRESS_WIDTH-1:0] fld_rd;

  id_ex_t dec_c;
  logic   reads_rs_c;
  logic   reads_rt_c;
  logic   hazard_c;
  logic   ready_c;
  logic   transfer_c;

  id_ex_t               ex_d, ex_q;
  logic                 ex_valid_d, ex_valid_q;
  logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

  assign op     = if_bus.if_instr[31:26];
  assign funct  = if_bus.if_instr[5:0];
  assign fld_rs = RF_ADDRESS_WIDTH'(if_bus.if_instr[25:21]);
  assign fld_rt = RF_ADDRESS_WIDTH'(if_bus.if_instr[20:16]);
  assign fld_rd = RF_ADDRESS_WIDTH'(if_bus.if_instr[15:11]);

  assign rs1 = fld_rs;
  assign rs2 = fld_rt;

  // Control decode; unsupported encodings carry only the illegal flag and read nothing.
  always_comb begin : decode
    dec_c        = '0;
    reads_rs_c   = 1'b0;
    reads_rt_c   = 1'b0;
    dec_c.rs1    = fld_rs;
    dec_c.rs2    = fld_rt;
    dec_c.imm    = DATA_WIDTH'(if_bus.if_instr[IMM_WIDTH-1:0]);
    dec_c.target = if_bus.if_instr[TARGET_WIDTH-1:0];
    case (op)
      OP_RTYPE: begin
        dec_c.reg_write = 1'b1;
        dec_c.dest      = fld_rd;
        reads_rs_c      = 1'b1;
        reads_rt_c      = 1'b1;
        case (funct)
          FN_ADD:  dec_c.alu_op = ALU_ADD;
          FN_SUB:  dec_c.alu_op = ALU_SUB;
          FN_AND:  dec_c.alu_op = ALU_AND;
          FN_OR:   dec_c.alu_op = ALU_OR;
          FN_SLT:  dec_c.alu_op = ALU_SLT;
          default: begin
            dec_c.illegal   = 1'b1;
            dec_c.reg_write = 1'b0;
            dec_c.dest      = '0;
            reads_rs_c      = 1'b0;
            reads_rt_c      = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_c.alu_src_imm = 1'b1;
        dec_c.reg_write   = 1'b1;
        dec_c.dest        = fld_rt;
        reads_rs_c        = 1'b1;
      end
      OP_LW: begin
        dec_c.alu_src_imm = 1'b1;
        dec_c.reg_write   = 1'b1;
        dec_c.mem_read    = 1'b1;
        dec_c.dest        = fld_rt;
        reads_rs_c        = 1'b1;
      end
      OP_SW: begin
        dec_c.alu_src_imm = 1'b1;
        dec_c.mem_write   = 1'b1;
        reads_rs_c        = 1'b1;
        reads_rt_c        = 1'b1;
      end
      OP_BEQ: begin
        dec_c.alu_op = ALU_SUB;
        dec_c.branch = 1'b1;
        reads_rs_c   = 1'b1;
        reads_rt_c   = 1'b1;
      end
      OP_J:    dec_c.jump    = 1'b1;
      default: dec_c.illegal = 1'b1;
    endcase
    if (dec_c.dest == '0) begin
      dec_c.reg_write = 1'b0;
    end
  end

  // Load-use: the load in ID/EX produces a register this instruction actually reads.
  assign hazard_c = ex_valid_q & ex_q.mem_read & (ex_q.dest != '0) & if_bus.if_valid &
                    ((reads_rs_c & (fld_rs == ex_q.dest)) |
                     (reads_rt_c & (fld_rt == ex_q.dest)));

  assign ready_c    = ~rst & (ex_bus.flush | (~hazard_c & (~ex_valid_q | ex_bus.ex_ready)));
  assign transfer_c = if_bus.if_valid & ready_c;

  assign if_bus.if_ready = ready_c;

  // ID/EX next state; flush outranks a bubble, so a flushed hazard is not counted.
  always_comb begin : next_state
    ex_d        = ex_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (ex_bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (hazard_c && ex_bus.ex_ready) begin
      ex_valid_d = 1'b0;
      if (stall_cnt_q != {CNT_WIDTH{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
    end else if (transfer_c) begin
      ex_d       = dec_c;
      ex_valid_d = 1'b1;
    end else if (ex_bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_bus.ex_valid       = ex_valid_q;
  assign ex_bus.ex_alu_op      = ex_q.alu_op;
  assign ex_bus.ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_bus.ex_reg_write   = ex_q.reg_write;
  assign ex_bus.ex_mem_read    = ex_q.mem_read;
  assign ex_bus.ex_mem_write   = ex_q.mem_write;
  assign ex_bus.ex_branch      = ex_q.branch;
  assign ex_bus.ex_jump        = ex_q.jump;
  assign ex_bus.ex_illegal     = ex_q.illegal;
  assign ex_bus.ex_dest        = ex_q.dest;
  assign ex_bus.ex_rs1         = ex_q.rs1;
  assign ex_bus.ex_rs2         = ex_q.rs2;
  assign ex_bus.ex_imm         = ex_q.imm;
  assign ex_bus.ex_target      = ex_q.target;
  assign stall_cnt             = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all checked against
// an instruction-level reference model of decode, hazard and ID/EX update rules.
module tb_id_stage;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [CNT_W-1:0] stall_cnt;

  if_id_if ifb ();
  id_ex_if #(.RF_ADDRESS_WIDTH(5), .DATA_WIDTH(16)) exb ();

  id_stage #(
    .RF_ADDRESS_WIDTH(5),
    .DATA_WIDTH      (16),
    .CNT_WIDTH       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_bus   (ifb),
    .ex_bus   (exb),
    .rs1      (rs1),
    .rs2      (rs2),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic        reads_rs;
    logic        reads_rt;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [25:0] target;
  } exp_t;

  // R-type funct codes, listed in ALU-op order
  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  exp_t             m_rec;
  logic             m_valid;
  logic [CNT_W-1:0] m_cnt;
  logic             m_took;
  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    e        = '0;
    e.rs     = ins[25:21];
    e.rt     = ins[20:16];
    e.imm    = ins[15:0];
    e.target = ins[25:0];
    case (ins[31:26])
      6'h00: begin
        e.illegal = 1'b1;
        for (int k = 0; k < 5; k++) begin
          if (ins[5:0] == fn_tab[k]) begin
            e.illegal  = 1'b0;
            e.alu_op   = 3'(k);
            e.reads_rs = 1'b1;
            e.reads_rt = 1'b1;
            e.dest     = ins[15:11];
          end
        end
      end
      6'h08, 6'h23: begin
        e.src_imm  = 1'b1;
        e.reads_rs = 1'b1;
        e.dest     = ins[20:16];
        e.mem_read = (ins[31:26] == 6'h23);
      end
      6'h2b: begin
        e.src_imm   = 1'b1;
        e.mem_write = 1'b1;
        e.reads_rs  = 1'b1;
        e.reads_rt  = 1'b1;
      end
      6'h04: begin
        e.alu_op   = 3'd1;
        e.branch   = 1'b1;
        e.reads_rs = 1'b1;
        e.reads_rt = 1'b1;
      end
      6'h02:   e.jump    = 1'b1;
      default: e.illegal = 1'b1;
    endcase
    e.reg_write = (e.dest != 5'd0);
    return e;
  endfunction

  function automatic logic ref_hazard(input logic v, input logic [31:0] ins);
    exp_t d;
    d = ref_decode(ins);
    return m_valid && m_rec.mem_read && (m_rec.dest != 5'd0) && v &&
           ((d.reads_rs && d.rs == m_rec.dest) || (d.reads_rt && d.rt == m_rec.dest));
  endfunction

  task automatic check_regs();
    check("ex_valid", 32'(exb.ex_valid), 32'(m_valid));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("ctrl", 32'({exb.ex_alu_op, exb.ex_alu_src_imm, exb.ex_reg_write, exb.ex_mem_read,
                       exb.ex_mem_write, exb.ex_branch, exb.ex_jump, exb.ex_illegal}),
                  32'({m_rec.alu_op, m_rec.src_imm, m_rec.reg_write, m_rec.mem_read,
                       m_rec.mem_write, m_rec.branch, m_rec.jump, m_rec.illegal}));
    if (m_rec.reg_write || m_rec.mem_read) check("ex_dest", 32'(exb.ex_dest), 32'(m_rec.dest));
    if (m_rec.reads_rs) check("ex_rs1", 32'(exb.ex_rs1), 32'(m_rec.rs));
    if (m_rec.reads_rt) check("ex_rs2", 32'(exb.ex_rs2), 32'(m_rec.rt));
    check("ex_imm", 32'(exb.ex_imm), 32'(m_rec.imm));
    check("ex_target", 32'(exb.ex_target), 32'(m_rec.target));
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance model, check registers.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic er,
                       input logic fl, input logic r);
    logic haz, rdy;
    ifb.if_valid  = v;
    ifb.if_instr  = ins;
    exb.ex_ready  = er;
    exb.flush     = fl;
    rst           = r;
    @(negedge clk);
    haz = ref_hazard(v, ins);
    rdy = !r && (fl || (!haz && (!m_valid || er)));
    check("if_ready", 32'(ifb.if_ready), 32'(rdy));
    check("rs1", 32'(rs1), 32'(ins[25:21]));
    check("rs2", 32'(rs2), 32'(ins[20:16]));
    m_took = v && rdy;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_rec   = '0;
      m_cnt   = '0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (haz && er) begin
      m_valid = 1'b0;
      if (m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
    end else if (v && rdy) begin
      m_valid = 1'b1;
      m_rec   = ref_decode(ins);
    end else if (er) begin
      m_valid = 1'b0;
    end
    #1;
    check_regs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, d;
    logic [15:0] im;
    logic [31:0] x;
    int          fi;
    a  = 5'($urandom_range(0, 3));
    b  = 5'($urandom_range(0, 3));
    d  = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    fi = int'($urandom_range(0, 4));
    case ($urandom_range(0, 9))
      0, 1:    x = {6'h00, a, b, d, 5'd0, fn_tab[fi]};
      2:       x = {6'h00, a, b, d, 5'($urandom), 6'($urandom)};
      3:       x = {6'h08, a, b, im};
      4, 5:    x = {6'h23, a, b, im};
      6:       x = {6'h2b, a, b, im};
      7:       x = {6'h04, a, b, im};
      8:       x = {6'h02, 26'($urandom)};
      default: x = $urandom;
    endcase
    return x;
  endfunction

  initial begin
    logic [31:0] cur;
    logic        curv;
    ifb.if_valid = 1'b0;
    ifb.if_instr = '0;
    exb.ex_ready = 1'b0;
    exb.flush    = 1'b0;
    rst          = 1'b1;
    m_valid      = 1'b0;
    m_rec        = '0;
    m_cnt        = '0;
    m_took       = 1'b0;
    @(posedge clk);
    #1;

    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_dest", 32'(exb.ex_dest), 32'd0);
    check("rst_ex_rs1", 32'(exb.ex_rs1), 32'd0);
    check("rst_ex_rs2", 32'(exb.ex_rs2), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("rdy_after_rst", 32'(ifb.if_ready), 32'd1);

    cycle(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b0);
    check("add_valid", 32'(exb.ex_valid), 32'd1);
    check("add_dest", 32'(exb.ex_dest), 32'd3);
    check("add_rw", 32'(exb.ex_reg_write), 32'd1);

    cycle(1'b1, 32'h8C250004, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A23020, 1'b1, 1'b0, 1'b0);
    check("bubble_valid", 32'(exb.ex_valid), 32'd0);
    check("bubble_cnt", 32'(stall_cnt), 32'd1);
    cycle(1'b1, 32'h00A23020, 1'b1, 1'b0, 1'b0);
    check("dep_issue", 32'(exb.ex_valid), 32'd1);
    check("dep_dest", 32'(exb.ex_dest), 32'd6);

    cycle(1'b1, 32'h8C250004, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00423020, 1'b1, 1'b0, 1'b0);
    check("nodep_issue", 32'(exb.ex_valid), 32'd1);
    check("nodep_cnt", 32'(stall_cnt), 32'd1);

    cycle(1'b1, 32'h8C200000, 1'b1, 1'b0, 1'b0);
    check("lw0_rw", 32'(exb.ex_reg_write), 32'd0);
    cycle(1'b1, 32'h00023020, 1'b1, 1'b0, 1'b0);
    check("r0_issue", 32'(exb.ex_valid), 32'd1);
    check("r0_cnt", 32'(stall_cnt), 32'd1);

    cycle(1'b1, 32'h20040007, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h00221820, 1'b0, 1'b0, 1'b0);
      check("bp_imm", 32'(exb.ex_imm), 32'd7);
      check("bp_valid", 32'(exb.ex_valid), 32'd1);
    end
    cycle(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b0);

    cycle(1'b1, 32'hAC220008, 1'b1, 1'b1, 1'b0);
    check("flush_valid", 32'(exb.ex_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("sw_dropped", 32'(exb.ex_mem_write), 32'd0);

    cycle(1'b1, 32'hFC000000, 1'b1, 1'b0, 1'b0);
    check("illegal_ctrl", 32'({exb.ex_alu_op, exb.ex_alu_src_imm, exb.ex_reg_write,
                               exb.ex_mem_read, exb.ex_mem_write, exb.ex_branch,
                               exb.ex_jump, exb.ex_illegal}), 32'd1);

    cycle(1'b1, 32'h8C250004, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A23020, 1'b1, 1'b1, 1'b0);
    check("flush_haz_cnt", 32'(stall_cnt), 32'd1);

    cur  = rand_instr();
    curv = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic r, fl, er;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 3) != 0);
      cycle(curv, cur, er, fl, r);
      if (!curv || m_took) begin
        cur  = rand_instr();
        curv = ($urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly upstream of the register file.
- Accepts 32-bit MIPS-subset instructions from IF over a valid/ready handshake, drives the register-file read addresses, and decodes control signals into an ID/EX pipeline register.
- Detects load-use hazards, inserts one bubble per hazard, honours branch flushes, and keeps a saturating stall counter.

Parameters:
- RF_ADDRESS_WIDTH, 5, register-address width; fixed at 5 by the instruction format.
- DATA_WIDTH, 16, data/immediate width; the immediate field is taken unextended.
- CNT_WIDTH, 16, width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  if_instr holds an instruction
- if_ready  out  1  stage accepts if_instr this cycle
- if_instr  in  32  instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0] target[25:0]
- flush  in  1  branch/jump taken downstream; kill the ID/EX contents
- rs1  out  5  register-file read address A = if_instr[25:21], combinational
- rs2  out  5  register-file read address B = if_instr[20:16], combinational
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  EX consumes ID/EX this cycle
- ex_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- ex_alu_src_imm  out  1  ALU operand B is the immediate
- ex_reg_write  out  1  writes ex_dest
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_branch  out  1  BEQ
- ex_jump  out  1  J
- ex_illegal  out  1  unsupported encoding
- ex_dest  out  5  destination register
- ex_rs1, ex_rs2  out  5 each  source registers, passed on for forwarding
- ex_imm  out  16  imm[15:0]
- ex_target  out  26  jump target
- stall_cnt  out  CNT_WIDTH  hazard bubbles inserted, saturating

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - ex_valid=0.
  - All ex_* control bits = 0; ex_dest, ex_rs1, ex_rs2, ex_imm, ex_target, ex_alu_op = 0.
  - stall_cnt=0.
  - The in-flight instruction is discarded.
  - if_ready is 0 while rst=1.
- Decode:
  - R-type (op 000000), selected by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. dest=rd; reads rs and rt.
  - ADDI (001000): ADD, imm operand, dest=rt; reads rs.
  - LW (100011): ADD, imm operand, mem_read, dest=rt; reads rs.
  - SW (101011): ADD, imm operand, mem_write, no write; reads rs and rt.
  - BEQ (000100): SUB, branch; reads rs and rt.
  - J (000010): jump; reads nothing.
  - Any other op or funct: ex_illegal=1, every other control bit 0. The instruction still propagates.
  - ex_reg_write is forced to 0 when dest=0.
- Hazard (combinational):
  - hazard = ex_valid & ex_mem_read & ex_dest!=0 & if_valid, and the decoded instruction either reads rs with rs==ex_dest or reads rt with rt==ex_dest.
  - Only sources the instruction actually reads count.
- Handshake:
  - if_ready = ~rst & (flush | (~hazard & (~ex_valid | ex_ready))).
  - A transfer occurs when if_valid & if_ready.
- ID/EX register update, in priority order at each edge:
  1. rst.
  2. flush: ex_valid<=0. Any transferring instruction is dropped, and if_ready=1 so IF can advance.
  3. hazard & ex_ready: ex_valid<=0 (bubble) and stall_cnt increments, unless stall_cnt is all-ones. The instruction stays at IF (if_ready=0).
  4. transfer: load the decoded fields and set ex_valid<=1.
  5. ex_ready & ~transfer: ex_valid<=0.
  6. Otherwise hold all fields.
- Latency:
  - Exactly 1 cycle from transfer to ex_valid.
  - Exactly 1 bubble per load-use hazard. The dependent instruction issues the cycle after the bubble.
- Back-pressure: with ex_valid=1 and ex_ready=0, all ex_* outputs are held stable and if_ready=0.
- Flush and hazard together: flush wins; no stall_cnt increment.
- rs1 and rs2 follow if_instr regardless of if_valid.

Test Plan:
- Reset with rst=1 for 2 cycles, then 0 → ex_valid=0, stall_cnt=0, if_ready=1 the cycle after release.
- ADD $3,$1,$2 (0x00221820) with ex_ready=1 → rs1=1, rs2=2 the same cycle; next cycle ex_valid=1, alu_op=0, reg_write=1, dest=3.
- LW $5,4($1) (0x8C250004), then ADD $6,$5,$2 (0x00A23020) → if_ready=0 for 1 cycle, 1 bubble (ex_valid=0), stall_cnt=1, then ADD issues. Repeat with ADD $6,$2,$2 → no bubble.
- LW $0,0($1) then ADD $6,$0,$2 → no hazard, and LW has reg_write=0.
- Hold ex_ready=0 for 3 cycles with ADDI $4,$0,7 (0x20040007) in ID/EX → all ex_* outputs stable, if_ready=0; ex_imm=7 throughout.
- Assert flush during a transfer of SW → ex_valid=0 next cycle and the SW is never presented. Separately, opcode 0x3F → ex_illegal=1 with all other control bits 0.
